ieee_norm_round: RTL and testbench

Post-add normalize/round/pack stage that sits directly downstream of the IEEE single-precision adder datapath. It accepts the adder's raw, unnormalized result (sign, biased exponent, 28-bit magnitude with carry and guard/round/sticky bits). It normalizes iteratively, one bit per cycle, then rounds to nearest-even and packs a 32-bit IEEE-754 word with status flags. Valid/ready handshakes on both sides let it stall the adder during long cancellation shifts.

---
 rtl/ieee_norm_round_pkg.sv | 24 ++
 rtl/ieee_norm_round_if.sv | 29 ++
 rtl/ieee_norm_round_rne_round.sv | 29 ++
 rtl/ieee_norm_round.sv | 159 +++++++++++++++
 tb/tb_ieee_norm_round.sv | 135 +++++++++++++
 5 files changed

// File: rtl/ieee_norm_round_pkg.sv
// Shared constants, FSM state encoding and the raw adder-result bundle
// for the single-precision post-add normalize/round stage.
package ieee_pkg;

    localparam int          MAG_W    = 28;
    localparam int          EXP_BIAS = 127;
    localparam logic [7:0]  EXP_MAX  = 8'hFF;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    // [27] carry, [26] hidden, [25:3] fraction, [2:0] guard/round/sticky
    typedef struct packed {
        logic             sign;
        logic [7:0]       exp;
        logic [MAG_W-1:0] mag;
    } raw_t;

endpackage

// File: rtl/ieee_norm_round_if.sv
// Handshake and data bundle between the adder, this stage and its consumer.
interface ieee_norm_round_if;
    import ieee_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic             in_sign;
    logic [7:0]       in_exp;
    logic [MAG_W-1:0] in_mag;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic             out_overflow;
    logic             out_underflow;
    logic             out_inexact;

    modport slave (
        input  in_valid, in_sign, in_exp, in_mag, out_ready,
        output in_ready, out_valid, out_result,
               out_overflow, out_underflow, out_inexact
    );

    modport master (
        output in_valid, in_sign, in_exp, in_mag, out_ready,
        input  in_ready, out_valid, out_result,
               out_overflow, out_underflow, out_inexact
    );
endinterface

// File: rtl/ieee_norm_round_rne_round.sv
// Round-to-nearest-even of a 24-bit significand with G/R/S, plus overflow detect.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module rne_round
    import ieee_pkg::*;
(
    input  logic [23:0] sig,
    input  logic        g,
    input  logic        r,
    input  logic        s,
    input  logic [8:0]  exp,
    output logic [23:0] sig_rnd,
    output logic [8:0]  exp_rnd,
    output logic        overflow,
    output logic        inexact
);
    logic        round_up;
    logic [24:0] sum;

    assign round_up = g & (r | s | sig[0]);
    assign sum      = {1'b0, sig} + {24'd0, round_up};

    // A carry out of the significand renormalizes to 1.0 at the next binade.
    assign sig_rnd  = sum[24] ? 24'h80_0000 : sum[23:0];
    assign exp_rnd  = sum[24] ? exp + 9'd1 : exp;
    assign overflow = (exp_rnd >= {1'b0, EXP_MAX});
    assign inexact  = g | r | s;

endmodule

// File: rtl/ieee_norm_round.sv
// Normalizes the raw adder result one bit per cycle, rounds RNE and packs IEEE-754.
// Latency: 1 cycle special/zero, 2 normal/carry, 2+k for k left shifts.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module ieee_norm_round
    import ieee_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    ieee_norm_round_if.slave  io
);
    state_t           state_q, state_d;
    logic             sign_q, sign_d;
    logic [8:0]       exp_q, exp_d;
    logic [MAG_W-1:0] mag_q, mag_d;
    logic             bypass_q, bypass_d;
    logic [31:0]      result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             inx_q, inx_d;
    logic             vld_q, vld_d;
    logic             rdy_q, rdy_d;

    logic [23:0]      sig_rnd;
    logic [8:0]       exp_rnd;
    logic             rnd_ovf;
    logic             rnd_inx;
    logic [7:0]       exp_field;

    rne_round u_rne (
        .sig      (mag_q[26:3]),
        .g        (mag_q[2]),
        .r        (mag_q[1]),
        .s        (mag_q[0]),
        .exp      (exp_q),
        .sig_rnd  (sig_rnd),
        .exp_rnd  (exp_rnd),
        .overflow (rnd_ovf),
        .inexact  (rnd_inx)
    );

    assign exp_field = sig_rnd[23] ? exp_rnd[7:0] : 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mag_q    <= '0;
            bypass_q <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inx_q    <= 1'b0;
            vld_q    <= 1'b0;
            rdy_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mag_q    <= mag_d;
            bypass_q <= bypass_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inx_q    <= inx_d;
            vld_q    <= vld_d;
            rdy_q    <= rdy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mag_d    = mag_q;
        bypass_d = bypass_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inx_d    = inx_q;
        vld_d    = vld_q;
        rdy_d    = rdy_q;

        case (state_q)
            IDLE: begin
                if (io.in_valid && rdy_q) begin
                    sign_d   = io.in_sign;
                    exp_d    = {1'b0, io.in_exp};
                    mag_d    = io.in_mag;
                    bypass_d = 1'b0;
                    rdy_d    = 1'b0;
                    state_d  = NORM;
                    // Specials and zero pass through ROUND untouched so every
                    // path spends at least one cycle there.
                    if (io.in_exp == EXP_MAX) begin
                        bypass_d = 1'b1;
                        result_d = (io.in_mag[25:3] != '0) ? QNAN
                                                           : {io.in_sign, EXP_MAX, 23'd0};
                        state_d  = ROUND;
                    end else if (io.in_mag == '0) begin
                        bypass_d = 1'b1;
                        result_d = 32'd0;
                        state_d  = ROUND;
                    end else if (io.in_mag[27]) begin
                        mag_d = {1'b0, io.in_mag[27:2], io.in_mag[1] | io.in_mag[0]};
                        exp_d = {1'b0, io.in_exp} + 9'd1;
                    end
                end
            end

            NORM: begin
                if (mag_q[26] || exp_q <= 9'd1) begin
                    state_d = ROUND;
                end else begin
                    mag_d = {mag_q[MAG_W-2:0], 1'b0};
                    exp_d = exp_q - 9'd1;
                end
            end

            ROUND: begin
                if (bypass_q) begin
                    ovf_d = 1'b0;
                    unf_d = 1'b0;
                    inx_d = 1'b0;
                end else if (rnd_ovf) begin
                    result_d = {sign_q, EXP_MAX, 23'd0};
                    ovf_d    = 1'b1;
                    unf_d    = 1'b0;
                    inx_d    = rnd_inx;
                end else begin
                    result_d = {sign_q, exp_field, sig_rnd[22:0]};
                    ovf_d    = 1'b0;
                    unf_d    = rnd_inx && (exp_field == 8'd0);
                    inx_d    = rnd_inx;
                end
                vld_d   = 1'b1;
                state_d = DONE;
            end

            DONE: begin
                if (io.out_ready) begin
                    vld_d   = 1'b0;
                    rdy_d   = 1'b1;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign io.in_ready      = rdy_q;
    assign io.out_valid     = vld_q;
    assign io.out_result    = result_q;
    assign io.out_overflow  = ovf_q;
    assign io.out_underflow = unf_q;
    assign io.out_inexact   = inx_q;

endmodule

// File: tb/tb_ieee_norm_round.sv
// Directed-vector bench for ieee_norm_round with hand-computed expected words.
module tb_ieee_norm_round;
    import ieee_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    ieee_norm_round_if io ();

    ieee_norm_round dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic run_vec(input string tag, input logic s, input logic [7:0] e,
                           input logic [27:0] m, input int lat_exp,
                           input logic [31:0] res_exp, input logic ovf_e,
                           input logic unf_e, input logic inx_e, input int hold);
        int lat;
        bit rdy_bad;
        @(posedge clk); #1;
        chk({tag, ".rdy_before"}, {31'd0, io.in_ready}, 32'd1);
        io.in_valid = 1'b1;
        io.in_sign  = s;
        io.in_exp   = e;
        io.in_mag   = m;
        @(posedge clk); #1;
        // Garbage on the input bus while busy must not disturb the result.
        io.in_valid = 1'b0;
        io.in_sign  = ~s;
        io.in_exp   = 8'h55;
        io.in_mag   = 28'(($urandom));
        lat     = 0;
        rdy_bad = 1'b0;
        while (io.out_valid !== 1'b1 && lat < 60) begin
            if (io.in_ready !== 1'b0) rdy_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".latency"}, lat, lat_exp);
        chk({tag, ".rdy_busy"}, {31'd0, rdy_bad}, 32'd0);
        chk({tag, ".result"}, io.out_result, res_exp);
        chk({tag, ".flags"}, {29'd0, io.out_overflow, io.out_underflow, io.out_inexact},
            {29'd0, ovf_e, unf_e, inx_e});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, ".hold_vld"}, {31'd0, io.out_valid}, 32'd1);
            chk({tag, ".hold_res"}, io.out_result, res_exp);
            chk({tag, ".hold_rdy"}, {31'd0, io.in_ready}, 32'd0);
        end
        io.out_ready = 1'b1;
        @(posedge clk); #1;
        io.out_ready = 1'b0;
        chk({tag, ".vld_after"}, {31'd0, io.out_valid}, 32'd0);
        chk({tag, ".rdy_after"}, {31'd0, io.in_ready}, 32'd1);
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        io.in_valid  = 1'b0;
        io.in_sign   = 1'b0;
        io.in_exp    = 8'd0;
        io.in_mag    = '0;
        io.out_ready = 1'b0;
        #12;
        chk("reset.in_ready", {31'd0, io.in_ready}, 32'd1);
        chk("reset.out_valid", {31'd0, io.out_valid}, 32'd0);
        chk("reset.result", io.out_result, 32'd0);
        chk("reset.flags", {29'd0, io.out_overflow, io.out_underflow, io.out_inexact}, 32'd0);
        rst_n = 1'b1;

        //        tag          s     exp     mag                        lat res            o  u  i  hold
        run_vec("normal",    1'b0, 8'd127, 28'h400_0000,              2, 32'h3F80_0000, 0, 0, 0, 0);
        run_vec("carry",     1'b0, 8'd127, 28'h800_0000,              2, 32'h4000_0000, 0, 0, 0, 0);
        run_vec("cancel",    1'b0, 8'd127, 28'h000_0008,             25, 32'h3400_0000, 0, 0, 0, 0);
        run_vec("tie_even",  1'b0, 8'd127, 28'h400_0004,              2, 32'h3F80_0000, 0, 0, 1, 0);
        run_vec("tie_odd",   1'b0, 8'd127, 28'h400_000C,              2, 32'h3F80_0002, 0, 0, 1, 0);
        run_vec("rnd_carry", 1'b0, 8'd127, 28'h7FF_FFFC,              2, 32'h4000_0000, 0, 0, 1, 0);
        run_vec("carry_stk", 1'b0, 8'd127, 28'h800_0001,              2, 32'h4000_0000, 0, 0, 1, 0);
        run_vec("neg12",     1'b1, 8'd130, 28'h600_0000,              2, 32'hC140_0000, 0, 0, 0, 0);
        run_vec("overflow",  1'b0, 8'd254, 28'h800_0000,              2, 32'h7F80_0000, 1, 0, 0, 0);
        run_vec("qnan",      1'b0, 8'd255, 28'h000_0008,              1, 32'h7FC0_0000, 0, 0, 0, 0);
        run_vec("neg_inf",   1'b1, 8'd255, 28'h400_0000,              1, 32'hFF80_0000, 0, 0, 0, 0);
        run_vec("zero",      1'b1, 8'd100, 28'h000_0000,              1, 32'h0000_0000, 0, 0, 0, 0);
        run_vec("min_norm",  1'b0, 8'd3,   28'h100_0000,              4, 32'h0080_0000, 0, 0, 0, 0);
        run_vec("subnorm",   1'b0, 8'd1,   28'h200_0000,              2, 32'h0040_0000, 0, 0, 0, 0);
        run_vec("sub_inx",   1'b0, 8'd1,   28'h200_0004,              2, 32'h0040_0000, 0, 1, 1, 0);
        run_vec("backpress", 1'b0, 8'd127, 28'h400_0000,              2, 32'h3F80_0000, 0, 0, 0, 5);

        // Reset while shifting: state must collapse immediately and stay idle.
        @(posedge clk); #1;
        io.in_valid = 1'b1;
        io.in_sign  = 1'b0;
        io.in_exp   = 8'd127;
        io.in_mag   = 28'h000_0008;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_mid.busy", {31'd0, io.in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid.out_valid", {31'd0, io.out_valid}, 32'd0);
        chk("rst_mid.in_ready", {31'd0, io.in_ready}, 32'd1);
        chk("rst_mid.result", io.out_result, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("rst_mid.discard", {31'd0, io.out_valid}, 32'd0);
        chk("rst_mid.idle", {31'd0, io.in_ready}, 32'd1);

        run_vec("post_rst",  1'b0, 8'd127, 28'h400_0000,              2, 32'h3F80_0000, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
